oram_responder: RTL

//  Responder side of the TMS1x00 oram interface. It holds the 512x32 program/ROM

---
 rtl/oram_responder_if.sv | 32 +++
 rtl/oram_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/oram_responder_if.sv
// ---------------------------------------------------------------------------
// oram_responder_if
//   Wishbone classic slave bundle between the Caravel bus and oram_responder.
//   Signals:
//     wbs_cyc_i / wbs_stb_i / wbs_we_i  cycle, strobe, write enable
//     wbs_sel_i [3:0]                   byte lane selects
//     wbs_adr_i [31:0]                  byte address
//     wbs_dat_i [31:0]                  write data
//     wbs_ack_o                         single-cycle acknowledge
//     wbs_dat_o [31:0]                  registered read data
//   Modports: master (bus side), slave (oram_responder side).
// ---------------------------------------------------------------------------
interface oram_responder_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/oram_responder.sv
// ---------------------------------------------------------------------------
// oram_responder
//   Holds the TMS1x00 program image (DEPTH x DATA_W) and answers the core's
//   oram_addr requests with oram_value one cycle later. Firmware loads and
//   inspects the image over a Wishbone classic slave; a 2-bit control word
//   holds the core in reset (bit0) and locks out image writes (bit1).
//   Ports:
//     wb_clk_i    single clock for Wishbone and oram
//     wb_rst_n    asynchronous active-low reset
//     wbs         Wishbone slave bundle (oram_responder_if.slave)
//     oram_addr   word address from the core
//     oram_value  registered word returned to the core
//     core_rst_o  active-high reset request to the core (control bit0)
//   Window map (byte offsets from BASE_ADDR, 4 KiB):
//     0x000-0x7FC image words, 0x800 control, everything else reads 0.
// ---------------------------------------------------------------------------
module oram_responder #(
   parameter int          ADDR_W    = 9,
   parameter int          DATA_W    = 32,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n,
   oram_responder_if.slave     wbs,
   input  logic [ADDR_W-1:0]   oram_addr,
   output logic [DATA_W-1:0]   oram_value,
   output logic                core_rst_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int LANES = DATA_W / 8;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [1:0]        ctrl_r;
   logic              ack_r;
   logic [DATA_W-1:0] rd_data_r;
   logic [DATA_W-1:0] oram_value_r;

   logic              hit_s;
   logic              acc_s;
   logic              mem_hit_s;
   logic              ctrl_hit_s;
   logic [ADDR_W-1:0] word_s;
   logic              mem_we_s;
   logic              ctrl_we_s;
   logic [DATA_W-1:0] rd_s;
   logic              unused_adr_s;

   // The byte offset inside a word carries no meaning for a word-wide slave.
   assign unused_adr_s = ^wbs.wbs_adr_i[1:0];

   // Address decode, transfer acceptance and Wishbone read-data selection.
   always_comb begin
      hit_s      = 1'b0;
      acc_s      = 1'b0;
      mem_hit_s  = 1'b0;
      ctrl_hit_s = 1'b0;
      word_s     = {ADDR_W{1'b0}};
      mem_we_s   = 1'b0;
      ctrl_we_s  = 1'b0;
      rd_s       = {DATA_W{1'b0}};

      hit_s      = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                   (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
      // A transfer is taken only while ack is low, so a held strobe after
      // ack cannot be double-counted in the ack cycle itself.
      acc_s      = hit_s & ~ack_r;
      mem_hit_s  = ~wbs.wbs_adr_i[11];
      ctrl_hit_s = (wbs.wbs_adr_i[11:2] == 10'h200);
      word_s     = wbs.wbs_adr_i[ADDR_W+1:2];
      // Reset gating keeps a write from committing on an edge where the
      // transfer is being abandoned.
      mem_we_s   = acc_s & wbs.wbs_we_i & mem_hit_s & ~ctrl_r[1] & wb_rst_n;
      ctrl_we_s  = acc_s & wbs.wbs_we_i & ctrl_hit_s & wbs.wbs_sel_i[0];

      if (mem_hit_s) begin
         rd_s = mem_r[word_s];
      end else if (ctrl_hit_s) begin
         rd_s = {{(DATA_W-2){1'b0}}, ctrl_r};
      end else begin
         rd_s = {DATA_W{1'b0}};
      end
   end

   // Image array: byte-lane writes from Wishbone, no reset.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we_s) begin
         for (int b = 0; b < LANES; b++) begin
            if (wbs.wbs_sel_i[b]) begin
               mem_r[word_s][b*8 +: 8] <= wbs.wbs_dat_i[b*8 +: 8];
            end
         end
      end
   end

   // Core read port: sampled every edge, so a same-edge write is seen next cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         oram_value_r <= {DATA_W{1'b0}};
      end else begin
         oram_value_r <= mem_r[oram_addr];
      end
   end

   // Wishbone ack, registered read data and control word.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ack_r     <= 1'b0;
         rd_data_r <= {DATA_W{1'b0}};
         ctrl_r    <= 2'b01;
      end else begin
         ack_r <= acc_s;
         if (acc_s & ~wbs.wbs_we_i) begin
            rd_data_r <= rd_s;
         end
         if (ctrl_we_s) begin
            ctrl_r <= wbs.wbs_dat_i[1:0];
         end
      end
   end

   assign wbs.wbs_ack_o = ack_r;
   assign wbs.wbs_dat_o = rd_data_r;
   assign oram_value    = oram_value_r;
   assign core_rst_o    = ctrl_r[0];

endmodule
